// File: rtl/reg_native_if2apb.sv
// Bridge from the forwarded reg_native_if request pulse to an APB3 master.
// Adds a PREADY timeout so a hung IP always returns an error ack.
module reg_native_if2apb #(
  parameter int BUS_DATA_WIDTH = 32,
  parameter int BUS_ADDR_WIDTH = 64,
  parameter int APB_ADDR_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 255,
  parameter logic [BUS_DATA_WIDTH-1:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req_vld,
  input  logic [BUS_ADDR_WIDTH-1:0] addr,
  input  logic                      wr_en,
  input  logic                      rd_en,
  input  logic [BUS_DATA_WIDTH-1:0] wr_data,
  output logic                      ack_vld,
  output logic [BUS_DATA_WIDTH-1:0] rd_data,
  output logic                      err_vld,
  output logic                      drop_flag,
  output logic                      psel,
  output logic                      penable,
  output logic                      pwrite,
  output logic [APB_ADDR_WIDTH-1:0] paddr,
  output logic [BUS_DATA_WIDTH-1:0] pwdata,
  input  logic [BUS_DATA_WIDTH-1:0] prdata,
  input  logic                      pready,
  input  logic                      pslverr
);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } state_t;

  localparam int CW =
    (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam bit TO_EN = (TIMEOUT_CYCLES > 0);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

  state_t                    state_q, state_d;
  logic [APB_ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [BUS_DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic                      pwrite_q, pwrite_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic                      ack_q, ack_d;
  logic                      err_q, err_d;
  logic [BUS_DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                      drop_q, drop_d;

  // Only the low address bits reach the APB side.
  logic unused_addr;
  assign unused_addr = ^addr;

  always_comb begin
    state_d  = state_q;
    paddr_d  = paddr_q;
    pwdata_d = pwdata_q;
    pwrite_d = pwrite_q;
    cnt_d    = cnt_q;
    ack_d    = 1'b0;
    err_d    = 1'b0;
    rdata_d  = '0;
    drop_d   = drop_q | (req_vld & (state_q != IDLE));
    unique case (state_q)
      IDLE: begin
        if (req_vld) begin
          if (wr_en ^ rd_en) begin
            paddr_d  = addr[APB_ADDR_WIDTH-1:0];
            pwdata_d = wr_data;
            pwrite_d = wr_en;
            state_d  = SETUP;
          end else begin
            state_d = RESP;
            ack_d   = 1'b1;
            err_d   = 1'b1;
            rdata_d = ERR_DATA;
          end
        end
      end
      SETUP: begin
        cnt_d   = '0;
        state_d = ACCESS;
      end
      ACCESS: begin
        if (pready) begin
          state_d = RESP;
          ack_d   = 1'b1;
          err_d   = pslverr;
          if (pslverr)       rdata_d = ERR_DATA;
          else if (!pwrite_q) rdata_d = prdata;
        end else if (TO_EN && cnt_q == CNT_LAST) begin
          state_d = RESP;
          ack_d   = 1'b1;
          err_d   = 1'b1;
          rdata_d = ERR_DATA;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      paddr_q  <= '0;
      pwdata_q <= '0;
      pwrite_q <= 1'b0;
      cnt_q    <= '0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
      drop_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      paddr_q  <= paddr_d;
      pwdata_q <= pwdata_d;
      pwrite_q <= pwrite_d;
      cnt_q    <= cnt_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
      drop_q   <= drop_d;
    end
  end

  assign psel      = (state_q == SETUP) || (state_q == ACCESS);
  assign penable   = (state_q == ACCESS);
  assign pwrite    = pwrite_q;
  assign paddr     = paddr_q;
  assign pwdata    = pwdata_q;
  assign ack_vld   = ack_q;
  assign err_vld   = err_q;
  assign rd_data   = rdata_q;
  assign drop_flag = drop_q;

endmodule

// File: tb/tb_reg_native_if2apb.sv
// Scoreboard bench for reg_native_if2apb with a small APB slave model.
// Stimulus pushes expected acks; a negedge monitor pops and compares.
module tb_reg_native_if2apb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_vld = 1'b0;
  logic [63:0] addr = '0;
  logic        wr_en = 1'b0;
  logic        rd_en = 1'b0;
  logic [31:0] wr_data = '0;
  logic        ack_vld;
  logic [31:0] rd_data;
  logic        err_vld;
  logic        drop_flag;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  reg_native_if2apb #(
    .BUS_DATA_WIDTH(32),
    .BUS_ADDR_WIDTH(64),
    .APB_ADDR_WIDTH(32),
    .TIMEOUT_CYCLES(4),
    .ERR_DATA(32'hDEAD_BEEF)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_vld(req_vld),
    .addr(addr),
    .wr_en(wr_en),
    .rd_en(rd_en),
    .wr_data(wr_data),
    .ack_vld(ack_vld),
    .rd_data(rd_data),
    .err_vld(err_vld),
    .drop_flag(drop_flag),
    .psel(psel),
    .penable(penable),
    .pwrite(pwrite),
    .paddr(paddr),
    .pwdata(pwdata),
    .prdata(prdata),
    .pready(pready),
    .pslverr(pslverr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          slv_wait = 0;
  logic        slv_hang = 1'b0;
  logic        slv_err = 1'b0;
  logic [31:0] slv_rdata = '0;
  int          wcnt = 0;

  always @(posedge clk) begin
    if (!penable) wcnt <= 0;
    else          wcnt <= wcnt + 1;
  end

  assign pready  = penable && !slv_hang && (wcnt >= slv_wait);
  assign pslverr = slv_err && pready;
  assign prdata  = slv_rdata;

  typedef struct {
    logic [31:0] rd;
    logic        err;
    int          at;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h want 0x%0h (cyc %0d)",
               nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && ack_vld) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ack: got ack want none (cyc %0d)",
                 cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("ack_rd_data", {32'h0, rd_data}, {32'h0, e.rd});
        chk("ack_err_vld", {63'h0, err_vld}, {63'h0, e.err});
        chk("ack_latency", 64'(cyc), 64'(e.at));
      end
    end
  end

  task automatic issue(input logic w, input logic r,
                       input logic [63:0] a, input logic [31:0] d,
                       input logic [31:0] erd, input logic eerr,
                       input int lat, input bit push);
    exp_t e;
    @(negedge clk);
    req_vld = 1'b1;
    wr_en   = w;
    rd_en   = r;
    addr    = a;
    wr_data = d;
    if (push) begin
      e.rd  = erd;
      e.err = eerr;
      e.at  = cyc + lat;
      q.push_back(e);
    end
    @(negedge clk);
    req_vld = 1'b0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL %s_missing_ack: got %0d pending want 0",
               nm, q.size());
      q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int acc;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_psel", {63'h0, psel}, 64'h0);
    chk("rst_penable", {63'h0, penable}, 64'h0);
    chk("rst_ack", {63'h0, ack_vld}, 64'h0);
    chk("rst_drop", {63'h0, drop_flag}, 64'h0);
    chk("rst_rd_data", {32'h0, rd_data}, 64'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Write, zero wait states.
    slv_wait = 0;
    issue(1'b1, 1'b0, 64'h1000_0040, 32'h1234_5678,
          32'h0, 1'b0, 3, 1'b1);
    chk("wr_setup_psel", {63'h0, psel}, 64'h1);
    chk("wr_setup_pen", {63'h0, penable}, 64'h0);
    @(negedge clk);
    chk("wr_acc_psel", {63'h0, psel}, 64'h1);
    chk("wr_acc_pen", {63'h0, penable}, 64'h1);
    chk("wr_paddr", {32'h0, paddr}, 64'h1000_0040);
    chk("wr_pwrite", {63'h0, pwrite}, 64'h1);
    chk("wr_pwdata", {32'h0, pwdata}, 64'h1234_5678);
    @(negedge clk);
    chk("wr_done_psel", {63'h0, psel}, 64'h0);
    wait_done("write");

    // Read with three wait states.
    slv_wait  = 3;
    slv_rdata = 32'hA5A5_0001;
    issue(1'b0, 1'b1, 64'h0000_0000_1000_0080, 32'h0,
          32'hA5A5_0001, 1'b0, 6, 1'b1);
    wait_done("read_wait");

    // Hung slave: four ACCESS cycles then error ack.
    slv_hang = 1'b1;
    issue(1'b0, 1'b1, 64'h0000_0000_1000_00C0, 32'h0,
          32'hDEAD_BEEF, 1'b1, 6, 1'b1);
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (penable) acc++;
      if (i == 4) chk("to_psel_low", {63'h0, psel}, 64'h0);
    end
    chk("to_access_cycles", 64'(acc), 64'd4);
    wait_done("timeout");
    slv_hang = 1'b0;

    // Slave error then good read.
    slv_wait = 0;
    slv_err  = 1'b1;
    issue(1'b0, 1'b1, 64'h10, 32'h0, 32'hDEAD_BEEF, 1'b1, 3, 1'b1);
    wait_done("slverr");
    slv_err   = 1'b0;
    slv_rdata = 32'h0BAD_F00D;
    issue(1'b0, 1'b1, 64'h14, 32'h0, 32'h0BAD_F00D, 1'b0, 3, 1'b1);
    wait_done("after_slverr");

    // Illegal requests never touch APB.
    issue(1'b1, 1'b1, 64'h20, 32'h0, 32'hDEAD_BEEF, 1'b1, 1, 1'b1);
    chk("ill_both_psel", {63'h0, psel}, 64'h0);
    @(negedge clk);
    chk("ill_both_psel2", {63'h0, psel}, 64'h0);
    wait_done("illegal_both");
    issue(1'b0, 1'b0, 64'h24, 32'h0, 32'hDEAD_BEEF, 1'b1, 1, 1'b1);
    chk("ill_none_psel", {63'h0, psel}, 64'h0);
    wait_done("illegal_none");
    chk("drop_still_clear", {63'h0, drop_flag}, 64'h0);

    // Request during ACCESS is dropped.
    slv_wait  = 3;
    slv_rdata = 32'h5555_AAAA;
    issue(1'b0, 1'b1, 64'h2000_0008, 32'h0,
          32'h5555_AAAA, 1'b0, 6, 1'b1);
    @(negedge clk);
    req_vld = 1'b1;
    wr_en   = 1'b1;
    addr    = 64'h3000_0000;
    wr_data = 32'hFFFF_FFFF;
    @(negedge clk);
    req_vld = 1'b0;
    wr_en   = 1'b0;
    chk("drop_flag_set", {63'h0, drop_flag}, 64'h1);
    chk("drop_paddr_held", {32'h0, paddr}, 64'h2000_0008);
    chk("drop_pwrite_held", {63'h0, pwrite}, 64'h0);
    wait_done("drop");
    repeat (3) @(negedge clk);
    chk("drop_sticky", {63'h0, drop_flag}, 64'h1);

    // Reset during ACCESS, then a clean read.
    slv_hang = 1'b1;
    issue(1'b0, 1'b1, 64'h40, 32'h0, 32'h0, 1'b0, 0, 1'b0);
    @(negedge clk);
    chk("pre_rst_pen", {63'h0, penable}, 64'h1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_psel", {63'h0, psel}, 64'h0);
    chk("mid_rst_pen", {63'h0, penable}, 64'h0);
    chk("mid_rst_ack", {63'h0, ack_vld}, 64'h0);
    chk("mid_rst_drop", {63'h0, drop_flag}, 64'h0);
    rst_n    = 1'b1;
    slv_hang = 1'b0;
    slv_wait = 0;
    slv_rdata = 32'hC0DE_0042;
    issue(1'b0, 1'b1, 64'h44, 32'h0, 32'hC0DE_0042, 1'b0, 3, 1'b1);
    wait_done("post_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
